// File: rtl/specsense_frag_reassembler.sv
// Rebuilds CVITA-fragmented spectrum frames into single AXI-stream frames,
// rewriting the header and padding out frames broken by loss or bad framing.
module specsense_frag_reassembler #(
  parameter int WIDTH          = 32,
  parameter int MAX_FRAME_LOG2 = 11,
  parameter int FRAG_LEN_LOG2  = 8
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic             clear,
  input  logic [3:0]       frame_len_log2,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  input  logic [127:0]     i_tuser,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [127:0]     o_tuser,
  output logic             o_frame_err,
  output logic [15:0]      err_cnt
);

  localparam int BW = MAX_FRAME_LOG2;
  localparam int FW = FRAG_LEN_LOG2;

  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [BW-1:0] BIN_ONE  = 1;
  localparam logic [BW:0]   LEN_ONE  = 1;
  localparam logic [FW-1:0] FRAG_ONE = 1;
  localparam logic [FW:0]   FL_ONE   = 1;
  localparam logic [3:0]    FL_LOG2  = 4'(FRAG_LEN_LOG2);

  logic [1:0]    state;
  logic [3:0]    len_q;
  logic [BW-1:0] bin_cnt;
  logic [FW-1:0] frag_cnt;
  logic [11:0]   exp_seq;
  logic [127:0]  hdr_q;
  logic          sof;

  logic          rst_any;
  logic [3:0]    len_eff;
  logic [BW:0]   l_full;
  logic [BW-1:0] last_bin;
  logic [BW-1:0] bin_nxt;
  logic [FW:0]   fl_full;
  logic [FW-1:0] frag_m1;
  logic [12:0]   idx_full;
  logic [11:0]   idx_mask;
  logic [11:0]   seq;
  logic [15:0]   hdr_len;
  logic [127:0]  hdr_new;
  logic          sync_start;
  logic          pass_mode;
  logic          seq_bad;
  logic          bin_last;
  logic          frag_end;
  logic          in_xfer;
  logic          out_xfer;
  logic          pass_xfer;
  logic          err_inc;

  assign rst_any = ce_rst | clear;

  // Frame geometry comes straight from the input until it is latched.
  assign len_eff  = (state == S_SYNC) ? frame_len_log2 : len_q;
  assign l_full   = LEN_ONE << len_eff;
  assign last_bin = BW'(l_full - LEN_ONE);
  assign bin_nxt  = bin_last ? '0 : bin_cnt + BIN_ONE;

  assign fl_full = (len_eff >= FL_LOG2) ? (FL_ONE << FL_LOG2)
                                        : (FL_ONE << len_eff);
  assign frag_m1 = FW'(fl_full - FL_ONE);

  assign idx_full = 13'd1 << (len_eff - FL_LOG2);
  assign idx_mask = (len_eff > FL_LOG2) ? 12'(idx_full - 13'd1) : 12'd0;

  assign seq     = i_tuser[123:112];
  assign hdr_len = 16'({l_full, 2'b00}) + 16'd8
                 + (i_tuser[125] ? 16'd8 : 16'd0);
  assign hdr_new = {i_tuser[127:112], hdr_len, i_tuser[95:0]};

  assign bin_last = (bin_cnt == last_bin);
  assign frag_end = (frag_cnt == frag_m1);

  assign sync_start = (state == S_SYNC) & i_tvalid & sof
                    & ((seq & idx_mask) == 12'd0);
  assign pass_mode  = (state == S_PASS) | sync_start;
  assign seq_bad    = (state == S_PASS) & i_tvalid & sof
                    & (seq != exp_seq);

  always_comb begin
    i_tready    = 1'b0;
    o_tvalid    = 1'b0;
    o_tdata     = '0;
    o_tlast     = 1'b0;
    o_frame_err = 1'b0;
    o_tuser     = '0;
    if (!rst_any) begin
      if (pass_mode && !seq_bad) begin
        i_tready = o_tready;
        o_tvalid = i_tvalid;
        o_tdata  = i_tdata;
        o_tlast  = bin_last;
        o_tuser  = (bin_cnt == '0) ? hdr_new : hdr_q;
      end else begin
        case (state)
          S_SYNC:  i_tready = 1'b1;
          S_DRAIN: i_tready = 1'b1;
          S_PAD: begin
            o_tvalid    = 1'b1;
            o_tlast     = bin_last;
            o_frame_err = bin_last;
            o_tuser     = hdr_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_xfer   = i_tvalid & i_tready;
  assign out_xfer  = o_tvalid & o_tready;
  assign pass_xfer = pass_mode & ~seq_bad & in_xfer;
  assign err_inc   = seq_bad | (pass_xfer & (i_tlast != frag_end));

  always_ff @(posedge ce_clk) begin
    if (rst_any) begin
      state    <= S_SYNC;
      len_q    <= '0;
      bin_cnt  <= '0;
      frag_cnt <= '0;
      exp_seq  <= '0;
      hdr_q    <= '0;
      sof      <= 1'b1;
      err_cnt  <= '0;
    end else begin
      if (err_inc && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      if (in_xfer)
        sof <= i_tlast;
      if (pass_xfer) begin
        if (bin_cnt == '0)
          hdr_q <= hdr_new;
        if (state == S_SYNC)
          len_q <= frame_len_log2;
        if (sof)
          exp_seq <= seq + 12'd1;
        bin_cnt  <= bin_nxt;
        frag_cnt <= (i_tlast | frag_end) ? '0 : frag_cnt + FRAG_ONE;
        // A frame end on this beat is emitted before the error is acted on.
        if (i_tlast && !frag_end)
          state <= (bin_nxt == '0) ? S_SYNC : S_PAD;
        else if (!i_tlast && frag_end)
          state <= S_DRAIN;
        else
          state <= S_PASS;
      end else if (seq_bad) begin
        state <= (bin_cnt == '0) ? S_SYNC : S_PAD;
      end else if (state == S_PAD && out_xfer) begin
        bin_cnt <= bin_nxt;
        if (bin_last)
          state <= S_SYNC;
      end else if (state == S_DRAIN && in_xfer && i_tlast) begin
        state <= (bin_cnt != '0) ? S_PAD : S_SYNC;
      end
    end
  end

endmodule

// File: tb/tb_specsense_frag_reassembler.sv
// Directed bench for specsense_frag_reassembler: clean frames, seq wrap,
// loss recovery, mid-stream start, early tlast, backpressure and reset.
module tb_specsense_frag_reassembler;

  logic         ce_clk = 1'b0;
  logic         ce_rst = 1'b1;
  logic         clear = 1'b0;
  logic [3:0]   frame_len_log2 = 4'd11;
  logic [31:0]  i_tdata = '0;
  logic         i_tlast = 1'b0;
  logic         i_tvalid = 1'b0;
  logic         i_tready;
  logic [127:0] i_tuser = '0;
  logic [31:0]  o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready = 1'b1;
  logic [127:0] o_tuser;
  logic         o_frame_err;
  logic [15:0]  err_cnt;

  specsense_frag_reassembler dut (
    .ce_clk(ce_clk),
    .ce_rst(ce_rst),
    .clear(clear),
    .frame_len_log2(frame_len_log2),
    .i_tdata(i_tdata),
    .i_tlast(i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .i_tuser(i_tuser),
    .o_tdata(o_tdata),
    .o_tlast(o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .o_tuser(o_tuser),
    .o_frame_err(o_frame_err),
    .err_cnt(err_cnt)
  );

  always #5 ce_clk = ~ce_clk;

  typedef struct {
    logic [31:0]  d;
    logic         l;
    logic [127:0] u;
  } beat_t;

  typedef struct {
    logic [31:0]  d;
    logic         l;
    logic         e;
    logic [127:0] u;
  } exp_t;

  beat_t src[$];
  exp_t  exq[$];
  exp_t  exq_after[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] mk_hdr(int sq, int len, bit ht);
    return {2'b00, ht, 1'b0, 12'(sq), 16'(len), 96'h1234_5678_9abc_def0_0f1e_2d3c};
  endfunction

  task automatic add_frag(int sq, int n, bit ht);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = 32'(sq * 256 + i);
      b.l = (i == n - 1);
      b.u = mk_hdr(sq % 4096, 4 * n + 8 + (ht ? 8 : 0), ht);
      src.push_back(b);
    end
  endtask

  task automatic exp_frag(int sq, int n, int hseq, int hlen, bit ht, bit fend);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = 32'(sq * 256 + i);
      e.l = fend && (i == n - 1);
      e.e = 1'b0;
      e.u = mk_hdr(hseq, hlen, ht);
      exq.push_back(e);
    end
  endtask

  task automatic exp_pad(int n, int hseq, int hlen);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = '0;
      e.l = (i == n - 1);
      e.e = (i == n - 1);
      e.u = mk_hdr(hseq, hlen, 1'b0);
      exq.push_back(e);
    end
  endtask

  task automatic do_clear(logic [3:0] fl);
    @(posedge ce_clk); #1;
    clear = 1'b1;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    frame_len_log2 = fl;
    @(negedge ce_clk);
    chk("clear_tready", 192'(i_tready), 192'(0));
    @(posedge ce_clk); #1;
    clear = 1'b0;
    @(negedge ce_clk);
    chk("clear_err_cnt", 192'(err_cnt), 192'(0));
  endtask

  task automatic run(int budget, bit bp, int rst_at);
    int outn = 0;
    int cyc = 0;
    bit done_rst = 0;
    bit post_rst = 0;
    exp_t e;
    while ((src.size() > 0 || exq.size() > 0) && cyc < budget) begin
      @(posedge ce_clk); #1;
      ce_rst = (rst_at >= 0) && (outn == rst_at) && !done_rst;
      i_tvalid = (src.size() > 0) && (!bp || $urandom_range(0, 3) != 0);
      if (src.size() > 0) begin
        i_tdata = src[0].d;
        i_tlast = src[0].l;
        i_tuser = src[0].u;
      end
      o_tready = !bp || ($urandom_range(0, 2) != 0);
      @(negedge ce_clk);
      cyc++;
      if (ce_rst) begin
        chk("rst_cycle_tready", 192'(i_tready), 192'(0));
        chk("rst_cycle_tvalid", 192'(o_tvalid), 192'(0));
        done_rst = 1;
        post_rst = 1;
        exq = exq_after;
        continue;
      end
      if (post_rst) begin
        chk("post_rst_tvalid", 192'(o_tvalid), 192'(0));
        chk("post_rst_err_cnt", 192'(err_cnt), 192'(0));
        post_rst = 0;
      end
      if (o_tvalid && o_tready) begin
        if (exq.size() == 0) begin
          chk("extra_out_beat", 192'(1), 192'(0));
        end else begin
          e = exq.pop_front();
          chk($sformatf("beat%0d", outn),
              {o_tdata, o_tlast, o_frame_err & o_tlast, o_tuser},
              {e.d, e.l, e.e, e.u});
        end
        outn++;
      end
      if (i_tvalid && i_tready)
        void'(src.pop_front());
    end
    ce_rst = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    if (cyc >= budget)
      chk("timeout", 192'(1), 192'(0));
    src.delete();
    exq.delete();
  endtask

  initial begin
    // reset state
    ce_rst = 1'b1;
    repeat (2) @(posedge ce_clk);
    @(negedge ce_clk);
    chk("rst_tready", 192'(i_tready), 192'(0));
    chk("rst_tvalid", 192'(o_tvalid), 192'(0));
    @(posedge ce_clk); #1;
    ce_rst = 1'b0;
    @(negedge ce_clk);
    chk("idle_tvalid", 192'(o_tvalid), 192'(0));
    chk("idle_tlast", 192'(o_tlast), 192'(0));
    chk("idle_tuser", 192'(o_tuser), 192'(0));
    chk("idle_err_cnt", 192'(err_cnt), 192'(0));
    chk("sync_tready", 192'(i_tready), 192'(1));

    // 1: clean 2048-bin frame
    do_clear(4'd11);
    for (int s = 0; s < 8; s++) begin
      add_frag(s, 256, 0);
      exp_frag(s, 256, 0, 8200, 0, s == 7);
    end
    run(4000, 0, -1);
    chk("t1_err_cnt", 192'(err_cnt), 192'(0));

    // 2: 64-bin frames across the seqnum wrap
    do_clear(4'd6);
    for (int k = 0; k < 8; k++) begin
      add_frag((4090 + k) % 4096, 64, 0);
      exp_frag((4090 + k) % 4096, 64, (4090 + k) % 4096, 264, 0, 1);
    end
    run(2000, 0, -1);
    chk("t2_err_cnt", 192'(err_cnt), 192'(0));

    // 3: fragment 3 lost
    do_clear(4'd11);
    for (int s = 0; s < 16; s++)
      if (s != 3) add_frag(s, 256, 0);
    for (int s = 0; s < 3; s++)
      exp_frag(s, 256, 0, 8200, 0, 0);
    exp_pad(1280, 0, 8200);
    for (int s = 8; s < 16; s++)
      exp_frag(s, 256, 8, 8200, 0, s == 15);
    run(8000, 0, -1);
    chk("t3_err_cnt", 192'(err_cnt), 192'(1));

    // 4: stream starts mid-frame, has_time set
    do_clear(4'd10);
    for (int s = 2; s < 8; s++)
      add_frag(s, 256, 1);
    for (int s = 4; s < 8; s++)
      exp_frag(s, 256, 4, 4112, 1, s == 7);
    run(3000, 0, -1);
    chk("t4_err_cnt", 192'(err_cnt), 192'(0));

    // 5: early tlast in fragment 1
    do_clear(4'd10);
    add_frag(0, 256, 0);
    add_frag(1, 100, 0);
    for (int s = 2; s < 8; s++)
      add_frag(s, 256, 0);
    exp_frag(0, 256, 0, 4104, 0, 0);
    exp_frag(1, 100, 0, 4104, 0, 0);
    exp_pad(668, 0, 4104);
    for (int s = 4; s < 8; s++)
      exp_frag(s, 256, 4, 4104, 0, s == 7);
    run(6000, 0, -1);
    chk("t5_err_cnt", 192'(err_cnt), 192'(1));

    // 6: random backpressure, reset at output beat 1000
    do_clear(4'd11);
    for (int s = 8; s < 16; s++)
      exp_frag(s, 256, 8, 8200, 0, s == 15);
    exq_after = exq;
    exq.delete();
    for (int s = 0; s < 8; s++)
      exp_frag(s, 256, 0, 8200, 0, s == 7);
    for (int s = 0; s < 16; s++)
      add_frag(s, 256, 0);
    run(30000, 1, 1000);
    chk("t6_err_cnt", 192'(err_cnt), 192'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
